// File: rtl/cache_2way_if.sv
// ---------------------------------------------------------------------------
// cache_2way_if
//   Bundles the processor word port and the block-wide memory port of
//   cache_2way.
//
//   Processor side : proc_read, proc_write, proc_addr, proc_wdata (to cache)
//                    proc_rdata, proc_stall (from cache, combinational)
//   Memory side    : mem_read, mem_write, mem_addr, mem_wdata (from cache,
//                    registered); mem_rdata, mem_ready (to cache)
//
//   slave  : the cache's view.
//   master : the surrounding system (processor + memory) view.
// ---------------------------------------------------------------------------
interface cache_2way_if #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4
);
    localparam int OFS = $clog2(WORDS);

    logic                    proc_read;
    logic                    proc_write;
    logic [ADDR_W-1:0]       proc_addr;
    logic [31:0]             proc_wdata;
    logic [31:0]             proc_rdata;
    logic                    proc_stall;

    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-OFS-1:0]   mem_addr;
    logic [32*WORDS-1:0]     mem_wdata;
    logic [32*WORDS-1:0]     mem_rdata;
    logic                    mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cache_2way.sv
// ---------------------------------------------------------------------------
// cache_2way
//   2-way set-associative, write-back, write-allocate cache between a 32-bit
//   word processor port and a block-wide memory port. True LRU per set
//   (invalid ways filled first). Misses run IDLE -> [WB ->] FILL -> IDLE; a
//   dirty victim is written back before the refill is requested.
//
//   Parameters : ADDR_W word-address width, WORDS words per block (pow2),
//                SETS sets (pow2).
//   Ports      : clk        - clock, rising edge
//                proc_reset - synchronous active-high reset
//                bus        - cache_2way_if.slave (processor + memory ports)
//
//   Address split: offset [OFS-1:0], index [OFS+IDX-1:OFS], tag above.
// ---------------------------------------------------------------------------
module cache_2way #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4,
    parameter int SETS   = 4
) (
    input  logic          clk,
    input  logic          proc_reset,
    cache_2way_if.slave   bus
);
    localparam int OFS = $clog2(WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_W - OFS - IDX;
    localparam int BLK = ADDR_W - OFS;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t state, state_nx;

    // Line storage: [set][way]
    logic [SETS-1:0][1:0]       valid;
    logic [SETS-1:0][1:0]       dirty;
    logic [SETS-1:0]            lru;      // way to evict next
    logic [TAG-1:0]             tag_q  [SETS][2];
    logic [WORDS-1:0][31:0]     data_q [SETS][2];

    logic                       victim_q;

    logic                       mem_read_q,  mem_read_nx;
    logic                       mem_write_q, mem_write_nx;
    logic [BLK-1:0]             mem_addr_q,  mem_addr_nx;
    logic [32*WORDS-1:0]        mem_wdata_q, mem_wdata_nx;

    // Address decode from the live request address
    logic [OFS-1:0]             ofs;
    logic [IDX-1:0]             idx;
    logic [TAG-1:0]             ptag;
    logic [BLK-1:0]             pblk;

    assign ofs  = bus.proc_addr[OFS-1:0];
    assign idx  = bus.proc_addr[OFS+IDX-1:OFS];
    assign ptag = bus.proc_addr[ADDR_W-1:OFS+IDX];
    assign pblk = bus.proc_addr[ADDR_W-1:OFS];

    logic [1:0] way_hit;
    logic       hit;
    logic       hit_way;
    logic       req;
    logic       wr_req;
    logic       vict_sel;

    always_comb begin
        for (int w = 0; w < 2; w++)
            way_hit[w] = valid[idx][w] && (tag_q[idx][w] == ptag);
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];   // tags are unique within a set
    assign req     = bus.proc_read | bus.proc_write;
    // read wins when both strobes are high
    assign wr_req  = bus.proc_write & ~bus.proc_read;

    assign bus.proc_rdata = hit ? data_q[idx][hit_way][ofs] : 32'h0;
    assign bus.proc_stall = req & (~hit | (state != IDLE));

    // Invalid ways are filled before LRU is consulted
    always_comb begin
        if (!valid[idx][0])      vict_sel = 1'b0;
        else if (!valid[idx][1]) vict_sel = 1'b1;
        else                     vict_sel = lru[idx];
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // ---------------- FSM: state + registered memory strobes ----------------
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state       <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_nx;
            mem_read_q  <= mem_read_nx;
            mem_write_q <= mem_write_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mem_read_nx  = mem_read_q;
        mem_write_nx = mem_write_q;
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    if (valid[idx][vict_sel] && dirty[idx][vict_sel]) begin
                        state_nx     = WB;
                        mem_write_nx = 1'b1;
                        mem_addr_nx  = {tag_q[idx][vict_sel], idx};
                        mem_wdata_nx = data_q[idx][vict_sel];
                    end else begin
                        state_nx     = FILL;
                        mem_read_nx  = 1'b1;
                        mem_addr_nx  = pblk;
                    end
                end
            end
            WB: begin
                if (bus.mem_ready) begin
                    state_nx     = FILL;
                    mem_write_nx = 1'b0;
                    mem_read_nx  = 1'b1;
                    mem_addr_nx  = pblk;
                end
            end
            FILL: begin
                if (bus.mem_ready) begin
                    state_nx    = IDLE;
                    mem_read_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- line storage ----------------
    // A write miss is not merged into the refill: once the line lands, the
    // still-held request hits in IDLE and is performed as a normal write hit.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            valid    <= '0;
            dirty    <= '0;
            lru      <= '0;
            victim_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            lru[idx] <= ~hit_way;
                            if (wr_req) begin
                                data_q[idx][hit_way][ofs] <= bus.proc_wdata;
                                dirty[idx][hit_way]       <= 1'b1;
                            end
                        end else begin
                            victim_q <= vict_sel;
                        end
                    end
                end
                WB: begin
                    // index is still the live one: proc_addr is held stable
                    if (bus.mem_ready)
                        dirty[idx][victim_q] <= 1'b0;
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        data_q[idx][victim_q] <= bus.mem_rdata;
                        tag_q[idx][victim_q]  <= ptag;
                        valid[idx][victim_q]  <= 1'b1;
                        dirty[idx][victim_q]  <= 1'b0;
                        lru[idx]              <= ~victim_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_2way.sv
// ---------------------------------------------------------------------------
// tb_cache_2way
//   Directed bench for cache_2way (WORDS=4, SETS=4: index [3:2], tag [29:4]).
//   A background memory model answers each strobe after LAT cycles; blocks
//   never written return word w of block a as 32'hA000_0000 | a<<4 | w.
// ---------------------------------------------------------------------------
module tb_cache_2way;
    localparam int ADDR_W = 30;
    localparam int WORDS  = 4;
    localparam int SETS   = 4;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic proc_reset;

    always #5 clk = ~clk;

    cache_2way_if #(.ADDR_W(ADDR_W), .WORDS(WORDS)) b ();

    cache_2way #(.ADDR_W(ADDR_W), .WORDS(WORDS), .SETS(SETS)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (b)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- memory model ----------------
    logic [127:0] backing [logic [27:0]];
    bit           auto_en     = 1'b1;
    bit           force_ready = 1'b0;
    int           wait_cnt    = 0;

    function automatic logic [127:0] pat_blk(input logic [27:0] blk);
        logic [127:0] r;
        for (int w = 0; w < 4; w++)
            r[32*w +: 32] = 32'hA000_0000 | (32'(blk) << 4) | 32'(w);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!auto_en) begin
            b.mem_ready = force_ready;
            wait_cnt    = 0;
        end else begin
            b.mem_ready = 1'b0;
            if (b.mem_read || b.mem_write) begin
                wait_cnt++;
                if (wait_cnt == LAT) begin
                    wait_cnt = 0;
                    if (b.mem_write)
                        backing[b.mem_addr] = b.mem_wdata;
                    else
                        b.mem_rdata = backing.exists(b.mem_addr) ?
                                      backing[b.mem_addr] : pat_blk(b.mem_addr);
                    b.mem_ready = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- access recorder ----------------
    int           stall_cnt;
    bit           saw_rd, saw_wr, saw_both, rd_after_wr;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [31:0]  last_rdata;

    task automatic access(input logic rd, input logic wr,
                          input logic [29:0] addr, input logic [31:0] wd);
        @(negedge clk);
        b.proc_read  = rd;
        b.proc_write = wr;
        b.proc_addr  = addr;
        b.proc_wdata = wd;
        stall_cnt = 0; saw_rd = 0; saw_wr = 0; saw_both = 0; rd_after_wr = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        #1;
        for (int n = 0; n <= 200; n++) begin
            if (b.mem_write && !saw_wr) begin
                saw_wr = 1; wr_addr = b.mem_addr; wr_data = b.mem_wdata;
            end
            if (b.mem_read && !saw_rd) begin
                saw_rd = 1; rd_addr = b.mem_addr; rd_after_wr = saw_wr;
            end
            if (b.mem_read && b.mem_write) saw_both = 1;
            if (!b.proc_stall) break;
            if (n == 200) begin
                checks++; failures++;
                $display("FAIL access_timeout addr=%h stall still high", addr);
                break;
            end
            stall_cnt++;
            @(negedge clk); #1;
        end
        last_rdata = b.proc_rdata;
        @(negedge clk);
        b.proc_read  = 1'b0;
        b.proc_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset   = 1'b1;
        b.proc_read  = 1'b0;
        b.proc_write = 1'b0;
        repeat (2) @(negedge clk);
        proc_reset   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        proc_reset   = 1'b1;
        b.proc_read  = 1'b0;
        b.proc_write = 1'b0;
        b.proc_addr  = '0;
        b.proc_wdata = '0;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        #1;
        checks++; if (b.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", b.mem_read); end
        checks++; if (b.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", b.mem_write); end
        checks++; if (b.mem_addr !== 28'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", b.mem_addr); end
        checks++; if (b.mem_wdata !== 128'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", b.mem_wdata); end
        checks++; if (b.proc_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", b.proc_stall); end
        checks++; if (b.proc_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", b.proc_rdata); end
    endtask

    task automatic test_cold_read();
        backing[28'h1] = 128'h44444444_33333333_22222222_11111111;
        access(1'b1, 1'b0, 30'h5, 32'h0);
        checks++; if (stall_cnt != 5) begin failures++; $display("FAIL cold_stall_cycles got=%0d exp=5", stall_cnt); end
        checks++; if (!saw_rd || rd_addr !== 28'h1) begin failures++; $display("FAIL cold_mem_addr got=%h seen=%0d exp=1", rd_addr, saw_rd); end
        checks++; if (saw_wr) begin failures++; $display("FAIL cold_no_wb got=1 exp=0"); end
        checks++; if (last_rdata !== 32'h22222222) begin failures++; $display("FAIL cold_rdata got=%h exp=22222222", last_rdata); end
    endtask

    task automatic test_rw_same();
        @(negedge clk);
        b.proc_read = 1'b1; b.proc_write = 1'b1; b.proc_addr = 30'h5; b.proc_wdata = 32'h0;
        #1;
        checks++; if (b.proc_stall !== 1'b0) begin failures++; $display("FAIL rw_stall got=%b exp=0", b.proc_stall); end
        checks++; if (b.proc_rdata !== 32'h22222222) begin failures++; $display("FAIL rw_rdata got=%h exp=22222222", b.proc_rdata); end
        @(negedge clk);
        b.proc_write = 1'b0;
        #1;
        checks++; if (b.proc_rdata !== 32'h22222222) begin failures++; $display("FAIL rw_stored got=%h exp=22222222", b.proc_rdata); end
        checks++; if (b.mem_read !== 1'b0 || b.mem_write !== 1'b0) begin failures++; $display("FAIL rw_no_mem got=%b%b exp=00", b.mem_read, b.mem_write); end
        @(negedge clk);
        b.proc_read = 1'b0;
    endtask

    task automatic test_lru();
        do_reset();
        access(1'b1, 1'b0, 30'h00, 32'h0);
        checks++; if (last_rdata !== 32'hA0000000) begin failures++; $display("FAIL lru_rd00 got=%h exp=a0000000", last_rdata); end
        access(1'b1, 1'b0, 30'h10, 32'h0);
        checks++; if (last_rdata !== 32'hA0000040 || rd_addr !== 28'h4) begin failures++; $display("FAIL lru_rd10 got=%h/%h exp=a0000040/4", last_rdata, rd_addr); end
        access(1'b1, 1'b0, 30'h00, 32'h0);
        checks++; if (stall_cnt != 0 || saw_rd || saw_wr) begin failures++; $display("FAIL lru_hit00 stall=%0d rd=%0d wr=%0d exp=0,0,0", stall_cnt, saw_rd, saw_wr); end
        access(1'b1, 1'b0, 30'h20, 32'h0);
        checks++; if (stall_cnt == 0 || saw_wr || rd_addr !== 28'h8) begin failures++; $display("FAIL lru_miss20 stall=%0d wr=%0d addr=%h exp=>0,0,8", stall_cnt, saw_wr, rd_addr); end
        checks++; if (last_rdata !== 32'hA0000080) begin failures++; $display("FAIL lru_rd20 got=%h exp=a0000080", last_rdata); end
        access(1'b1, 1'b0, 30'h00, 32'h0);
        checks++; if (stall_cnt != 0 || last_rdata !== 32'hA0000000) begin failures++; $display("FAIL lru_kept00 stall=%0d data=%h exp=0,a0000000", stall_cnt, last_rdata); end
        access(1'b1, 1'b0, 30'h10, 32'h0);
        checks++; if (stall_cnt == 0 || last_rdata !== 32'hA0000040) begin failures++; $display("FAIL lru_evicted10 stall=%0d data=%h exp=>0,a0000040", stall_cnt, last_rdata); end
    endtask

    task automatic test_dirty_wb();
        do_reset();
        access(1'b0, 1'b1, 30'h01, 32'hDEADBEEF);
        checks++; if (saw_wr || rd_addr !== 28'h0) begin failures++; $display("FAIL wb_first_fill wr=%0d addr=%h exp=0,0", saw_wr, rd_addr); end
        access(1'b1, 1'b0, 30'h01, 32'h0);
        checks++; if (stall_cnt != 0 || last_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_written stall=%0d data=%h exp=0,deadbeef", stall_cnt, last_rdata); end
        access(1'b1, 1'b0, 30'h10, 32'h0);
        checks++; if (saw_wr) begin failures++; $display("FAIL wb_rd10_no_wb got=1 exp=0"); end
        access(1'b1, 1'b0, 30'h20, 32'h0);
        checks++; if (!saw_wr || wr_addr !== 28'h0) begin failures++; $display("FAIL wb_addr seen=%0d got=%h exp=0", saw_wr, wr_addr); end
        checks++; if (wr_data !== 128'hA0000003_A0000002_DEADBEEF_A0000000) begin failures++; $display("FAIL wb_data got=%h exp=a0000003a0000002deadbeefa0000000", wr_data); end
        checks++; if (!rd_after_wr || rd_addr !== 28'h8 || saw_both) begin failures++; $display("FAIL wb_then_fill order=%0d addr=%h both=%0d exp=1,8,0", rd_after_wr, rd_addr, saw_both); end
        checks++; if (last_rdata !== 32'hA0000080) begin failures++; $display("FAIL wb_rd20 got=%h exp=a0000080", last_rdata); end
        access(1'b1, 1'b0, 30'h01, 32'h0);
        checks++; if (stall_cnt == 0 || saw_wr || last_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_refetch stall=%0d wr=%0d data=%h exp=>0,0,deadbeef", stall_cnt, saw_wr, last_rdata); end
    endtask

    task automatic test_write_miss();
        do_reset();
        access(1'b0, 1'b1, 30'h36, 32'hCAFEF00D);
        checks++; if (!saw_rd || rd_addr !== 28'hD || saw_wr) begin failures++; $display("FAIL wm_fill seen=%0d addr=%h wr=%0d exp=1,d,0", saw_rd, rd_addr, saw_wr); end
        checks++; if (stall_cnt != 5) begin failures++; $display("FAIL wm_stall_cycles got=%0d exp=5", stall_cnt); end
        access(1'b1, 1'b0, 30'h36, 32'h0);
        checks++; if (stall_cnt != 0 || last_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL wm_readback stall=%0d data=%h exp=0,cafef00d", stall_cnt, last_rdata); end
        access(1'b1, 1'b0, 30'h16, 32'h0);
        checks++; if (saw_wr || last_rdata !== 32'hA0000052) begin failures++; $display("FAIL wm_rd16 wr=%0d data=%h exp=0,a0000052", saw_wr, last_rdata); end
        // evicts the 0x36 line, which must be dirty
        access(1'b1, 1'b0, 30'h26, 32'h0);
        checks++; if (!saw_wr || wr_addr !== 28'hD) begin failures++; $display("FAIL wm_dirty_wb seen=%0d addr=%h exp=1,d", saw_wr, wr_addr); end
        checks++; if (wr_data !== 128'hA00000D3_CAFEF00D_A00000D1_A00000D0) begin failures++; $display("FAIL wm_wb_data got=%h exp=a00000d3cafef00da00000d1a00000d0", wr_data); end
        checks++; if (rd_addr !== 28'h9 || last_rdata !== 32'hA0000092) begin failures++; $display("FAIL wm_rd26 addr=%h data=%h exp=9,a0000092", rd_addr, last_rdata); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        auto_en = 1'b0; force_ready = 1'b0;
        @(negedge clk);
        b.proc_read = 1'b1; b.proc_addr = 30'h5;
        @(negedge clk); #1;
        checks++; if (b.mem_read !== 1'b1 || b.mem_addr !== 28'h1) begin failures++; $display("FAIL rst_fill_started rd=%b addr=%h exp=1,1", b.mem_read, b.mem_addr); end
        @(negedge clk);
        proc_reset = 1'b1; force_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (b.mem_read !== 1'b0 || b.mem_write !== 1'b0) begin failures++; $display("FAIL rst_strobes_drop got=%b%b exp=00", b.mem_read, b.mem_write); end
        b.proc_read = 1'b0; proc_reset = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (b.mem_read !== 1'b0 || b.mem_write !== 1'b0 || b.proc_stall !== 1'b0) begin failures++; $display("FAIL rst_stray_ready rd=%b wr=%b stall=%b exp=0,0,0", b.mem_read, b.mem_write, b.proc_stall); end
        end
        force_ready = 1'b0;
        repeat (2) @(negedge clk);
        b.proc_read = 1'b1; b.proc_addr = 30'h5;
        #1;
        checks++; if (b.proc_stall !== 1'b1 || b.proc_rdata !== 32'h0) begin failures++; $display("FAIL rst_reread_miss stall=%b data=%h exp=1,0", b.proc_stall, b.proc_rdata); end
        auto_en = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk); #1;
            if (!b.proc_stall) break;
            if (n == 100) begin failures++; $display("FAIL rst_reread_timeout stall still high"); end
        end
        checks++; if (b.proc_rdata !== 32'h22222222) begin failures++; $display("FAIL rst_reread_data got=%h exp=22222222", b.proc_rdata); end
        @(negedge clk);
        b.proc_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_rw_same();
        test_lru();
        test_dirty_wb();
        test_write_miss();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
